// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32 instruction fetch controller.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry fetch buffer; entry 0 is always the head. Flush wins over push and pop.
module fetch_queue
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic         head_valid,
  output logic [1:0]   occupancy
);

  fetch_entry_t ent0;
  fetch_entry_t ent1;
  logic [1:0]   count;
  logic         pop_ok;

  assign pop_ok = pop & (count != 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent0  <= '0;
      ent1  <= '0;
      count <= 2'd0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push, pop_ok})
        2'b10: begin
          if (count == 2'd0) ent0 <= din;
          else               ent1 <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          ent0  <= ent1;
          count <= count - 2'd1;
        end
        2'b11: begin
          // head leaves, new word lands behind whatever remains
          if (count == 2'd2) begin
            ent0 <= ent1;
            ent1 <= din;
          end else begin
            ent0 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign head       = ent0;
  assign head_valid = (count != 2'd0);
  assign occupancy  = count;

  a_push_room: assert property (@(posedge clk) disable iff (rst) push |-> (count < 2'd2));

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, one outstanding imem request,
// a 2-entry return buffer and the IF-side inputs of the IF/ID register.
//
//   state | meaning
//   IDLE  | no request; buffer has no room after this cycle's pop
//   REQ   | imem_req high at fetch_pc, waiting for gnt
//   WAIT  | granted, response will be buffered
//   DROP  | granted, response is wrong-path and will be discarded
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        hold_d,
  output logic [31:0] instr_f,
  output logic [31:0] pc_f,
  output logic [31:0] pc_plus4_f,
  output logic        fetch_stall
);

  localparam logic [1:0] QD = 2'(QDEPTH);

  fetch_state_t state, state_nxt;
  logic [31:0]  fetch_pc, fetch_pc_nxt;

  fetch_entry_t head;
  fetch_entry_t push_entry;
  logic         head_valid;
  logic [1:0]   occupancy;
  logic         pop;
  logic         push;
  logic [1:0]   occ_after;
  logic [1:0]   occ_after_push;

  assign pop            = head_valid & ~hold_d & ~redirect;
  assign occ_after      = occupancy - {1'b0, pop};
  assign occ_after_push = occ_after + 2'd1;
  assign push           = (state == WAIT) & imem_rvalid & ~redirect;
  assign push_entry     = '{instr: imem_rdata, pc: fetch_pc};

  fetch_queue u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .flush      (redirect),
    .din        (push_entry),
    .head       (head),
    .head_valid (head_valid),
    .occupancy  (occupancy)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    case (state)
      IDLE: begin
        if (redirect || (occ_after < QD)) state_nxt = REQ;
      end
      REQ: begin
        if (imem_gnt) state_nxt = redirect ? DROP : WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (redirect) begin
            state_nxt = REQ;
          end else begin
            fetch_pc_nxt = fetch_pc + 32'd4;
            state_nxt    = (occ_after_push < QD) ? REQ : IDLE;
          end
        end else if (redirect) begin
          state_nxt = DROP;
        end
      end
      DROP: begin
        // the outstanding response retires here, so a concurrent redirect cannot keep us in DROP
        if (imem_rvalid) state_nxt = REQ;
      end
      default: state_nxt = IDLE;
    endcase
    if (redirect) fetch_pc_nxt = redirect_pc;
  end

  assign imem_req  = (state == REQ);
  assign imem_addr = fetch_pc;

  always_comb begin
    instr_f    = NOP_INSTR;
    pc_f       = 32'h0;
    pc_plus4_f = 32'h0;
    if (head_valid && !redirect) begin
      instr_f    = head.instr;
      pc_f       = head.pc;
      pc_plus4_f = head.pc + 32'd4;
    end
  end

  assign fetch_stall = hold_d & ~redirect;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus randomized traffic
// checked against a program-order reference of the delivered instruction stream.
module tb_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        hold_d;
  logic [31:0] instr_f;
  logic [31:0] pc_f;
  logic [31:0] pc_plus4_f;
  logic        fetch_stall;

  fetch_ctrl #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .hold_d      (hold_d),
    .instr_f     (instr_f),
    .pc_f        (pc_f),
    .pc_plus4_f  (pc_plus4_f),
    .fetch_stall (fetch_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return ((a * 32'h9E37_79B1) ^ 32'h5BD1_E995) | 32'h8000_0000;
  endfunction

  // instruction memory responder state
  bit          mem_busy = 0;
  int          mem_wait = 0;
  logic [31:0] mem_addr = 32'h0;
  int          mem_tag  = 0;
  int          gnt_pct  = 100;
  int          lat_max  = 0;
  bit          lat_rand = 0;

  // reference: program-order stream after the last redirect/reset
  logic [31:0] exp_pc   = 32'h0;
  int          epoch    = 0;
  int          buffered = 0;
  int          starve   = 0;

  logic        s_req, s_stall;
  logic [31:0] s_addr, s_instr, s_pc, s_p4;

  task automatic cycle();
    bit gnt_now;
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (mem_busy && !rst) begin
      if (mem_wait == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(mem_addr);
      end else begin
        mem_wait--;
      end
    end
    gnt_now  = imem_req && ($urandom_range(99) < gnt_pct);
    imem_gnt = gnt_now;
    #1;
    s_req = imem_req; s_addr = imem_addr; s_instr = instr_f;
    s_pc  = pc_f;     s_p4   = pc_plus4_f; s_stall = fetch_stall;

    if (redirect) begin
      check("redir_instr", instr_f, NOP);
      check("redir_pc", pc_f, 32'h0);
    end else if (instr_f != NOP) begin
      check("pc_f", pc_f, exp_pc);
      check("instr_f", instr_f, mem_word(exp_pc));
      check("pc_plus4_f", pc_plus4_f, exp_pc + 32'd4);
      check("spurious", 32'(buffered != 0), 32'd1);
    end else begin
      check("bubble_pc", pc_f, 32'h0);
      check("bubble_p4", pc_plus4_f, 32'h0);
      check("bubble_q", 32'(buffered), 32'd0);
    end
    check("stall", 32'(fetch_stall), 32'(hold_d & !redirect));
    if (imem_req) begin
      check("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
      check("one_outst", 32'(mem_busy), 32'd0);
    end

    if (!rst) begin
      if (!redirect && instr_f != NOP && !hold_d) begin
        exp_pc = exp_pc + 32'd4;
        buffered--;
      end
      if (imem_rvalid) begin
        mem_busy = 0;
        if (mem_tag == epoch && !redirect) buffered++;
      end
      if (gnt_now) begin
        mem_busy = 1;
        mem_addr = imem_addr;
        mem_tag  = epoch;
        mem_wait = lat_rand ? $urandom_range(lat_max) : lat_max;
      end
      if (redirect) begin
        exp_pc   = redirect_pc;
        epoch++;
        buffered = 0;
      end
      check("q_bound", 32'(buffered <= 2), 32'd1);
      if (!hold_d && !redirect && instr_f == NOP) starve++;
      else starve = 0;
      check("live", 32'(starve < 64), 32'd1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    hold_d   = 1'b0;
    redirect = 1'b0;
    do begin
      cycle();
      n++;
    end while (s_instr == NOP && n < 40);
    check(tag, 32'(s_instr != NOP), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; hold_d = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;

    repeat (2) cycle();
    check("rst_req", 32'(s_req), 32'd0);
    check("rst_instr", s_instr, NOP);
    check("rst_pc", s_pc, 32'h0);
    check("rst_p4", s_p4, 32'h0);
    check("rst_stall", 32'(s_stall), 32'd0);

    // first fetch latency
    rst = 1'b0;
    cycle(); check("c0_req", 32'(s_req), 32'd0);
    cycle(); check("c1_req", 32'(s_req), 32'd1); check("c1_addr", s_addr, 32'h0);
    cycle(); check("c2_req", 32'(s_req), 32'd0);
    cycle();
    check("c3_instr", s_instr, 32'h0050_0093);
    check("c3_pc", s_pc, 32'h0);
    check("c3_p4", s_p4, 32'h4);
    check("c3_next_addr", s_addr, 32'h4);

    // hold fills the buffer and stops requests
    hold_d = 1'b1;
    repeat (6) cycle();
    check("hold_req", 32'(s_req), 32'd0);
    check("hold_stall", 32'(s_stall), 32'd1);
    check("hold_q", 32'(buffered), 32'd2);
    check("hold_head", s_pc, 32'h4);
    hold_d = 1'b0;
    cycle(); check("rel_pc0", s_pc, 32'h4);
    lat_max = 2;
    cycle(); check("rel_pc1", s_pc, 32'h8);

    // redirect while WAIT, late response dropped
    redirect = 1'b1; redirect_pc = 32'h100;
    cycle();
    check("rw_instr", s_instr, NOP);
    check("rw_stall", 32'(s_stall), 32'd0);
    redirect = 1'b0;
    cycle(); check("drop_req0", 32'(s_req), 32'd0);
    cycle(); check("drop_req1", 32'(s_req), 32'd0); check("drop_instr", s_instr, NOP);
    lat_max = 0;
    cycle(); check("rw_req", 32'(s_req), 32'd1); check("rw_addr", s_addr, 32'h100);
    wait_valid("rw_deliver");
    check("rw_first_pc", s_pc, 32'h100);

    // redirect during REQ with grant held low
    gnt_pct = 0;
    n = 0;
    do begin cycle(); n++; end while (!s_req && n < 20);
    check("rq_seen", 32'(s_req), 32'd1);
    redirect = 1'b1; redirect_pc = 32'h200;
    cycle(); check("rq_req_redir", 32'(s_req), 32'd1);
    redirect = 1'b0;
    cycle(); check("rq_addr0", s_addr, 32'h200); check("rq_req0", 32'(s_req), 32'd1);
    cycle(); check("rq_addr1", s_addr, 32'h200);
    gnt_pct = 100;
    wait_valid("rq_deliver");
    check("rq_pc", s_pc, 32'h200);

    // redirect together with hold and a full buffer
    hold_d = 1'b1;
    n = 0;
    do begin cycle(); n++; end while (!(buffered == 2 && !s_req) && n < 20);
    check("rh_fill", 32'(buffered), 32'd2);
    redirect = 1'b1; redirect_pc = 32'h300;
    cycle();
    check("rh_stall", 32'(s_stall), 32'd0);
    check("rh_instr", s_instr, NOP);
    redirect = 1'b0;
    cycle();
    check("rh_empty_instr", s_instr, NOP);
    check("rh_empty_q", 32'(buffered), 32'd0);
    check("rh_stall_after", 32'(s_stall), 32'd1);
    wait_valid("rh_deliver");
    check("rh_pc", s_pc, 32'h300);

    // PC wrap
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cycle();
    wait_valid("wrap_a");
    check("wrap_pc", s_pc, 32'hFFFF_FFFC);
    check("wrap_p4", s_p4, 32'h0);
    wait_valid("wrap_b");
    check("wrap_next_pc", s_pc, 32'h0);

    // async reset in the middle of WAIT
    lat_max = 3;
    n = 0;
    do begin cycle(); n++; end while (!mem_busy && n < 20);
    check("mr_busy", 32'(mem_busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mr_req", 32'(imem_req), 32'd0);
    check("mr_addr", imem_addr, 32'h0);
    check("mr_instr", instr_f, NOP);
    check("mr_pc", pc_f, 32'h0);
    check("mr_p4", pc_plus4_f, 32'h0);
    check("mr_stall", 32'(fetch_stall), 32'd0);
    mem_busy = 0; epoch++; buffered = 0; exp_pc = 32'h0; starve = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    lat_max = 0;
    wait_valid("mr_deliver");
    check("mr_restart_pc", s_pc, 32'h0);

    // randomized traffic
    for (int blk = 0; blk < 12; blk++) begin
      gnt_pct  = $urandom_range(100, 30);
      lat_rand = 1;
      lat_max  = $urandom_range(3);
      for (int i = 0; i < 250; i++) begin
        hold_d      = ($urandom_range(99) < 30);
        redirect    = ($urandom_range(99) < 5);
        redirect_pc = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(9) == 0) redirect_pc = 32'hFFFF_FFF8;
        cycle();
      end
    end
    hold_d = 1'b0;
    redirect = 1'b0;
    repeat (4) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
